// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared element width, loader state encoding and element index helper
package matrix_pkg;

  localparam int ELEM_W = 8;

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } state_t;

  // Bit offset of element k inside a flattened row-major matrix
  function automatic int elem_lsb(input int k);
    return k * ELEM_W;
  endfunction

endpackage

// File: rtl/matrix_loader_if.sv
// rtl/matrix_loader_if.sv - element stream in, assembled matrix out, with consumer ack
interface matrix_loader_if #(
  parameter int N = 3
);
  import matrix_pkg::*;

  localparam int CW = $clog2(N * N + 1);

  logic [ELEM_W-1:0]       elem_in;
  logic                    elem_valid;
  logic                    elem_ready;
  logic                    abort;
  logic                    matrix_ack;
  logic [N*N*ELEM_W-1:0]   matrix_out;
  logic                    matrix_valid;
  logic [CW-1:0]           elem_count;

  modport master (
    output elem_in, elem_valid, abort, matrix_ack,
    input  elem_ready, matrix_out, matrix_valid, elem_count
  );

  modport slave (
    input  elem_in, elem_valid, abort, matrix_ack,
    output elem_ready, matrix_out, matrix_valid, elem_count
  );

endinterface

// File: rtl/matrix_transpose.sv
// rtl/matrix_transpose.sv - registered transpose of a flattened row-major N x N matrix
module matrix_transpose
  import matrix_pkg::*;
#(
  parameter int N = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N*N*ELEM_W-1:0]   matrix_in,
  input  logic                    matrix_in_valid,
  output logic [N*N*ELEM_W-1:0]   matrix_t,
  output logic                    matrix_t_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      matrix_t       <= '0;
      matrix_t_valid <= 1'b0;
    end else begin
      matrix_t_valid <= matrix_in_valid;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          matrix_t[elem_lsb(i * N + j) +: ELEM_W] <= matrix_in[elem_lsb(j * N + i) +: ELEM_W];
        end
      end
    end
  end

endmodule

// File: rtl/matrix_loader.sv
// rtl/matrix_loader.sv - assembles N*N row-major elements into a flattened matrix held until acked
module matrix_loader
  import matrix_pkg::*;
#(
  parameter int N = 3
) (
  input  logic              clk,
  input  logic              rst,
  matrix_loader_if.slave    bus
);

  localparam int NE = N * N;
  localparam int CW = $clog2(NE + 1);

  state_t                  state_q;
  state_t                  state_nx;
  logic [CW-1:0]           count_q;
  logic [NE*ELEM_W-1:0]    data_q;
  logic                    accept;
  logic                    last_elem;
  logic [NE-1:0]           we;

  assign accept    = (state_q == LOAD) && bus.elem_valid && !bus.abort;
  assign last_elem = (count_q == CW'(NE - 1));

  // One write enable per element slot; only the slot matching the count fires
  for (genvar k = 0; k < NE; k++) begin : g_we
    assign we[k] = accept && (count_q == CW'(k));
  end

  always_comb begin
    state_nx = state_q;
    if (bus.abort) begin
      state_nx = LOAD;
    end else begin
      case (state_q)
        LOAD: if (accept && last_elem) state_nx = FULL;
        FULL: if (bus.matrix_ack)      state_nx = LOAD;
        default:                       state_nx = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (bus.abort) begin
      count_q <= '0;
    end else if (state_q == FULL && bus.matrix_ack) begin
      count_q <= '0;
    end else if (accept) begin
      count_q <= count_q + CW'(1);
    end
  end

  // After an ack the old bytes stay until overwritten; only abort and reset clear them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (bus.abort) begin
      data_q <= '0;
    end else begin
      for (int k = 0; k < NE; k++) begin
        if (we[k]) data_q[elem_lsb(k) +: ELEM_W] <= bus.elem_in;
      end
    end
  end

  assign bus.elem_ready   = (state_q == LOAD);
  assign bus.matrix_valid = (state_q == FULL);
  assign bus.matrix_out   = data_q;
  assign bus.elem_count   = count_q;

endmodule

// File: tb/tb_matrix_loader.sv
// tb/tb_matrix_loader.sv - directed scoreboard bench for matrix_loader and the transpose stage
module tb_matrix_loader;

  localparam int N  = 3;
  localparam int NE = N * N;
  localparam int MW = NE * 8;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  logic [MW-1:0] sb_q[$];
  logic [MW-1:0] last_exp;
  logic [MW-1:0] t_out;
  logic          t_valid;

  matrix_loader_if #(.N(N)) bus ();

  matrix_loader #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  matrix_transpose #(.N(N)) u_tr (
    .clk             (clk),
    .rst             (rst),
    .matrix_in       (bus.matrix_out),
    .matrix_in_valid (bus.matrix_valid),
    .matrix_t        (t_out),
    .matrix_t_valid  (t_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Feed NE elements start, start+1, ...; with gap, elem_valid drops every other cycle
  task automatic feed(input logic [7:0] start, input bit gap);
    logic [MW-1:0] exp;
    exp = '0;
    for (int i = 0; i < NE; i++) exp[i*8 +: 8] = start + 8'(i);
    sb_q.push_back(exp);
    for (int i = 0; i < NE; i++) begin
      bus.elem_in    = start + 8'(i);
      bus.elem_valid = 1'b1;
      cyc();
      if (gap && i < NE - 1) begin
        bus.elem_valid = 1'b0;
        bus.elem_in    = 8'hEE;
        cyc();
      end
    end
    bus.elem_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    int waited;
    waited = 0;
    while (!bus.matrix_valid && waited < 20) begin
      cyc();
      waited++;
    end
    chk({tag, "_valid"}, 128'(bus.matrix_valid), 128'(1));
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 128'(0), 128'(1));
    end else begin
      last_exp = sb_q.pop_front();
      chk({tag, "_data"}, 128'(bus.matrix_out), 128'(last_exp));
    end
  endtask

  task automatic ack();
    bus.matrix_ack = 1'b1;
    cyc();
    bus.matrix_ack = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst            = 1'b1;
    bus.elem_in    = '0;
    bus.elem_valid = 1'b0;
    bus.abort      = 1'b0;
    bus.matrix_ack = 1'b0;
    cyc();
    cyc();
    chk("rst_valid", 128'(bus.matrix_valid), 128'(0));
    chk("rst_ready", 128'(bus.elem_ready), 128'(1));
    chk("rst_count", 128'(bus.elem_count), 128'(0));
    chk("rst_out", 128'(bus.matrix_out), 128'(0));
    rst = 1'b0;
    cyc();

    // Basic load with latency check on the final handshake
    feed(8'h01, 1'b0);
    chk("basic_lat_valid", 128'(bus.matrix_valid), 128'(1));
    chk("basic_count", 128'(bus.elem_count), 128'(9));
    chk("basic_ready", 128'(bus.elem_ready), 128'(0));
    chk("basic_const", 128'(bus.matrix_out), 128'(72'h090807060504030201));
    pop_check("basic");

    // Backpressure: elements offered while full are ignored
    bus.elem_in    = 8'hFF;
    bus.elem_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_hold", 128'(bus.matrix_out), 128'(last_exp));
      chk("bp_count", 128'(bus.elem_count), 128'(9));
    end
    bus.elem_valid = 1'b0;
    ack();
    chk("ack_valid", 128'(bus.matrix_valid), 128'(0));
    chk("ack_ready", 128'(bus.elem_ready), 128'(1));
    chk("ack_count", 128'(bus.elem_count), 128'(0));
    chk("ack_keep", 128'(bus.matrix_out), 128'(last_exp));

    // Gapped input
    feed(8'h10, 1'b1);
    chk("gap_count", 128'(bus.elem_count), 128'(9));
    pop_check("gap");
    ack();

    // Ack in LOAD is ignored; abort beats a simultaneous element
    for (int i = 0; i < 4; i++) begin
      bus.elem_in    = 8'h21 + 8'(i);
      bus.elem_valid = 1'b1;
      cyc();
      if (i == 1) begin
        bus.elem_valid = 1'b0;
        ack();
        chk("load_ack_ignored", 128'(bus.elem_count), 128'(2));
      end
    end
    chk("part_count", 128'(bus.elem_count), 128'(4));
    bus.elem_in    = 8'hAA;
    bus.elem_valid = 1'b1;
    bus.abort      = 1'b1;
    cyc();
    bus.abort      = 1'b0;
    bus.elem_valid = 1'b0;
    chk("abort_count", 128'(bus.elem_count), 128'(0));
    chk("abort_out", 128'(bus.matrix_out), 128'(0));
    chk("abort_valid", 128'(bus.matrix_valid), 128'(0));
    chk("abort_ready", 128'(bus.elem_ready), 128'(1));

    // Async reset mid-load
    for (int i = 0; i < 5; i++) begin
      bus.elem_in    = 8'h31 + 8'(i);
      bus.elem_valid = 1'b1;
      cyc();
    end
    bus.elem_valid = 1'b0;
    chk("pre_rst_count", 128'(bus.elem_count), 128'(5));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_count", 128'(bus.elem_count), 128'(0));
    chk("async_out", 128'(bus.matrix_out), 128'(0));
    chk("async_valid", 128'(bus.matrix_valid), 128'(0));
    #1;
    rst = 1'b0;
    cyc();

    // Fresh load feeding the transpose stage
    feed(8'h01, 1'b0);
    pop_check("chain");
    chk("chain_t_pre", 128'(t_valid), 128'(0));
    cyc();
    chk("chain_t_valid", 128'(t_valid), 128'(1));
    chk("chain_t_data", 128'(t_out), 128'(72'h090603080502070401));
    ack();
    chk("chain_ack_valid", 128'(bus.matrix_valid), 128'(0));
    chk("sb_drained", 128'(sb_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
